// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, majority-vote bit recovery and a show-ahead
// receive FIFO with sticky framing/overrun flags.
module uart_rx_fifo #(
    parameter int unsigned CLKFREQ    = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clear
);

    localparam int unsigned DIV = (CLKFREQ + BAUD * 8) / (BAUD * 16);
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam logic [DW-1:0] DivLast = DW'(DIV - 1);
    localparam logic [CW-1:0] CntFull = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic          sync1_q, sync2_q, prev_q;
    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    s_q, s_d;
    logic [1:0]    ones_q, ones_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          push_q, push_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic tick, maj, fe_set, full, pop, wr_en, ovr_set;

    // Receiver FSM, oversampling divider and vote accumulation
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        ones_d  = ones_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        push_d  = 1'b0;
        fe_set  = 1'b0;
        tick    = (state_q != StIdle) && (div_q == DivLast);
        div_d   = (state_q == StIdle || tick) ? '0 : div_q + 1'b1;
        maj     = (ones_q == 2'd2) || ((ones_q == 2'd1) && sync2_q);

        if (state_q == StIdle) begin
            if (prev_q && !sync2_q) begin
                state_d = StStart;
                s_d     = 4'd0;
                ones_d  = 2'd0;
                bit_d   = 3'd0;
            end
        end else if (tick) begin
            s_d = s_q + 4'd1;
            if (s_q == 4'd7) begin
                ones_d = {1'b0, sync2_q};
            end else if (s_q == 4'd8) begin
                ones_d = ones_q + {1'b0, sync2_q};
            end else if (s_q == 4'd9) begin
                ones_d = 2'd0;
                if (state_q == StStart) begin
                    state_d = maj ? StIdle : StData;
                end else if (state_q == StData) begin
                    shreg_d = {maj, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    push_d  = maj;
                    fe_set  = !maj;
                    state_d = StIdle;
                end
            end
        end
    end

    // FIFO control; a push into a full FIFO succeeds only if a pop frees a slot this cycle
    always_comb begin
        rx_valid = (cnt_q != '0);
        full     = (cnt_q == CntFull);
        pop      = rx_valid && rx_ready;
        wr_en    = push_q && (!full || pop);
        ovr_set  = push_q && full && !pop;
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !wr_en) begin
            cnt_d = cnt_q - 1'b1;
        end
        frame_err_d = fe_set | (frame_err_q & ~err_clear);
        overrun_d   = ovr_set | (overrun_q & ~err_clear);
        rx_data     = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
        rx_count    = cnt_q;
        frame_err   = frame_err_q;
        overrun     = overrun_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= StIdle;
            div_q       <= '0;
            s_q         <= 4'd0;
            ones_q      <= 2'd0;
            bit_q       <= 3'd0;
            shreg_q     <= 8'h00;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= rxd;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            div_q       <= div_d;
            s_q         <= s_d;
            ones_q      <= ones_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Storage needs no reset: contents are only visible while counted as valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shreg_q;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: serial frames driven bit by bit, received bytes
// checked against a queue of expected bytes as they are popped.
module tb_uart_rx_fifo;

    // Clock chosen so one bit is exactly 16 ticks of 4 clocks at 115200 baud
    localparam int unsigned CLK_HZ = 7372800;
    localparam int unsigned BAUD   = 115200;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned BIT    = CLK_HZ / BAUD;
    localparam int unsigned GLITCH = BIT * 100 / 434;

    logic       clk = 1'b0;
    logic       rst_n, rxd, rx_ready, err_clear;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun;
    logic [4:0] rx_count;

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    int unsigned rise_cyc = 0;
    int unsigned t0, lat;
    logic        valid_prev = 1'b0;
    logic [7:0]  exp_q [$];

    uart_rx_fifo #(
        .CLKFREQ   (CLK_HZ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_count (rx_count),
        .frame_err(frame_err),
        .overrun  (overrun),
        .err_clear(err_clear)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !valid_prev) rise_cyc = cyc;
        valid_prev = rx_valid;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input logic keep);
        if (keep) exp_q.push_back(b);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = stop;
        repeat (BIT) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!rx_valid && n < 20 * BIT) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(rx_valid), 32'd1);
    endtask

    task automatic pop_one(input string tag);
        logic [31:0] e;
        wait_valid({tag, "_valid"});
        if (exp_q.size() != 0) e = 32'(exp_q.pop_front());
        else e = 32'h100;
        check_eq(tag, 32'(rx_data), e);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b1; rxd = 1'b1; rx_ready = 1'b0; err_clear = 1'b0;
        #5 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("rst_valid", 32'(rx_valid), 0);
        check_eq("rst_data", 32'(rx_data), 0);
        check_eq("rst_count", 32'(rx_count), 0);
        check_eq("rst_ferr", 32'(frame_err), 0);
        check_eq("rst_ovr", 32'(overrun), 0);

        // Single byte, then pop
        t0 = cyc;
        send_byte(8'h55, 1'b1, 1'b1);
        wait_valid("t1_valid");
        lat = rise_cyc - t0;
        check_eq("t1_count", 32'(rx_count), 1);
        pop_one("t1_data");
        @(negedge clk);
        check_eq("t1_valid_after", 32'(rx_valid), 0);
        check_eq("t1_count_after", 32'(rx_count), 0);

        // Short low glitch on an idle line
        rxd = 1'b0;
        repeat (GLITCH) @(negedge clk);
        rxd = 1'b1;
        repeat (20 * BIT) @(negedge clk);
        check_eq("t2_count", 32'(rx_count), 0);
        check_eq("t2_ferr", 32'(frame_err), 0);
        check_eq("t2_ovr", 32'(overrun), 0);

        // Bad stop bit
        send_byte(8'hA3, 1'b0, 1'b0);
        repeat (BIT) @(negedge clk);
        check_eq("t3_ferr", 32'(frame_err), 1);
        check_eq("t3_count", 32'(rx_count), 0);
        pulse_clear();
        check_eq("t3_ferr_clr", 32'(frame_err), 0);

        // Seventeen bytes into a sixteen-entry FIFO
        for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1, i < 16);
        repeat (2 * BIT) @(negedge clk);
        check_eq("t4_count", 32'(rx_count), 16);
        check_eq("t4_ovr", 32'(overrun), 1);
        for (int i = 0; i < 16; i++) pop_one("t4_data");
        @(negedge clk);
        check_eq("t4_count_end", 32'(rx_count), 0);
        check_eq("t4_valid_end", 32'(rx_valid), 0);
        pulse_clear();
        check_eq("t4_ovr_clr", 32'(overrun), 0);

        // Pop coinciding with the push cycle while full
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i), 1'b1, 1'b1);
        repeat (2 * BIT) @(negedge clk);
        check_eq("t5_full", 32'(rx_count), 16);
        t0 = cyc;
        fork
            send_byte(8'h30, 1'b1, 1'b1);
            begin
                logic [31:0] e;
                while (cyc < t0 + lat - 1) @(negedge clk);
                e = (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'h100;
                check_eq("t5_head", 32'(rx_data), e);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        check_eq("t5_count", 32'(rx_count), 16);
        check_eq("t5_ovr", 32'(overrun), 0);
        for (int i = 0; i < 16; i++) pop_one("t5_data");
        @(negedge clk);
        check_eq("t5_count_end", 32'(rx_count), 0);

        // Reset in the middle of a data bit, with state held beforehand
        send_byte(8'h77, 1'b1, 1'b0);
        send_byte(8'h5A, 1'b0, 1'b0);
        repeat (BIT) @(negedge clk);
        check_eq("t6_pre_ferr", 32'(frame_err), 1);
        rxd = 1'b0;
        repeat (3 * BIT + BIT / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("t6_valid", 32'(rx_valid), 0);
        check_eq("t6_data", 32'(rx_data), 0);
        check_eq("t6_count", 32'(rx_count), 0);
        check_eq("t6_ferr", 32'(frame_err), 0);
        check_eq("t6_ovr", 32'(overrun), 0);
        repeat (2 * BIT) @(negedge clk);
        send_byte(8'h3C, 1'b1, 1'b1);
        pop_one("t6_rx");
        @(negedge clk);
        check_eq("t6_count_end", 32'(rx_count), 0);
        check_eq("t6_ferr_end", 32'(frame_err), 0);
        check_eq("sb_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
